stats_frame_tx: RTL and testbench

- Serialises a snapshot of the pet's five stats and sleep flag into a fixed 8-byte framed packet.
- Sends the packet over a UART 8N1 line to the host monitor.
- It is the transmit-side counterpart of the command receive path: the host parses these frames for display and logging.
- Sits beside the stats block; typically triggered by the one-second tick.

---
 rtl/stats_frame_tx_pkg.sv | 30 +++
 rtl/stats_frame_tx_uart_tx_byte.sv | 120 ++++++++++++
 rtl/stats_frame_tx.sv | 127 ++++++++++++
 tb/tb_stats_frame_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stats_frame_tx_pkg.sv
// Shared definitions for the stats frame transmitter: frame constants,
// serialiser state encoding, stats snapshot layout and the CRC-8 step.
package stats_frame_tx_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  typedef struct packed {
    logic [4:0] hunger;
    logic [4:0] happiness;
    logic [4:0] hygiene;
    logic [4:0] energy;
    logic [4:0] social;
    logic       is_sleeping;
  } stats_t;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/stats_frame_tx_uart_tx_byte.sv
// UART 8N1 byte serialiser. Owns the bit timer and bit index.
// A start strobe seen in IDLE, or on the last cycle of a stop bit, loads
// data_i and begins a start bit on the next edge, so bytes chain with no gap.
//
// state | meaning
// IDLE  | line high, waiting for start_i
// START | start bit (0) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1); byte_done_o high on its last cycle
module stats_frame_tx_uart_tx_byte
  import stats_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       byte_done_o
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tc;

  assign tc          = (timer_q == TIMER_MAX);
  assign byte_done_o = (state_q == STOP) && tc;
  assign tx_o        = tx_q;

  // State register; the line is forced high the moment reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic; tx_d is the line level for the coming bit so tx stays registered.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start_i) begin
          state_d   = START;
          timer_d   = '0;
          bit_idx_d = '0;
          shift_d   = data_i;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (tc) begin
          state_d   = DATA;
          timer_d   = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (tc) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (tc) begin
          timer_d = '0;
          if (start_i) begin
            state_d   = START;
            bit_idx_d = '0;
            shift_d   = data_i;
            tx_d      = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/stats_frame_tx.sv
// Stats frame transmitter: snapshots the pet stats on an accepted send and
// sends header, five stats, sleep flag and a check byte over UART 8N1.
// Build option STATS_TX_CRC8_EN: check byte is CRC-8 (poly 0x07) over
// bytes 1..6 instead of their XOR. Frame length and timing are unchanged.
module stats_frame_tx
  import stats_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [4:0] hunger,
  input  logic [4:0] happiness,
  input  logic [4:0] hygiene,
  input  logic [4:0] energy,
  input  logic [4:0] social,
  input  logic       is_sleeping,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  stats_t     snap_q, snap_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       start_q, start_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic [2:0] load_idx;
  logic [7:0] pay [6];
  logic [7:0] chk;
  logic [7:0] load_byte;
  logic       accept;
  logic       byte_done;
  logic       byte_start;

  assign accept = send && !busy_q;

  // start_q launches byte 0 one edge after acceptance; later bytes chain off byte_done.
  assign load_idx   = start_q ? 3'd0 : byte_idx_q + 3'd1;
  assign byte_start = start_q || (byte_done && (byte_idx_q != LAST_IDX));

  assign pay[0] = {3'b000, snap_q.hunger};
  assign pay[1] = {3'b000, snap_q.happiness};
  assign pay[2] = {3'b000, snap_q.hygiene};
  assign pay[3] = {3'b000, snap_q.energy};
  assign pay[4] = {3'b000, snap_q.social};
  assign pay[5] = {7'b0000000, snap_q.is_sleeping};

  // Check byte over the snapshot payload; settles long before the last byte loads.
  always_comb begin
    chk = 8'h00;
    for (int i = 0; i < 6; i++) begin
`ifdef STATS_TX_CRC8_EN
      chk = crc8_update(chk, pay[i]);
`else
      chk = chk ^ pay[i];
`endif
    end
  end

  // Byte to hand the serialiser when it next takes a start strobe.
  always_comb begin
    load_byte = FRAME_HDR;
    case (load_idx)
      3'd0:    load_byte = FRAME_HDR;
      3'd7:    load_byte = chk;
      default: load_byte = pay[load_idx - 3'd1];
    endcase
  end

  // Frame-level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      byte_idx_q <= '0;
    end else begin
      snap_q     <= snap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      start_q    <= start_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Accept/snapshot and byte sequencing; send while busy is dropped.
  always_comb begin
    snap_d     = snap_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    start_d    = 1'b0;
    byte_idx_d = byte_idx_q;
    if (accept) begin
      snap_d     = '{hunger, happiness, hygiene, energy, social, is_sleeping};
      busy_d     = 1'b1;
      start_d    = 1'b1;
      byte_idx_d = '0;
    end else if (byte_done) begin
      if (byte_idx_q == LAST_IDX) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        byte_idx_d = byte_idx_q + 3'd1;
      end
    end
  end

  stats_frame_tx_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .reset      (reset),
    .start_i    (byte_start),
    .data_i     (load_byte),
    .tx_o       (uart_tx),
    .byte_done_o(byte_done)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_stats_frame_tx.sv
// Directed bench for stats_frame_tx: decodes the serial line with a UART
// receiver model and compares bytes, done timing and busy behaviour.
module tb_stats_frame_tx;

  localparam int C = 87;

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [4:0] hunger, happiness, hygiene, energy, social;
  logic       is_sleeping;
  logic       uart_tx, busy, done;

  always #5 clk = ~clk;

  stats_frame_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .send       (send),
    .hunger     (hunger),
    .happiness  (happiness),
    .hygiene    (hygiene),
    .energy     (energy),
    .social     (social),
    .is_sleeping(is_sleeping),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .done       (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt  = 0;
  int done_last = 0;
  int done_prev = 0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_prev = done_last;
      done_last = cyc;
      done_cnt++;
    end
  end

  // UART receiver model, sampling mid-bit.
  logic [7:0] rxq[$];
  int         rxs[$];
  int         rx_err  = 0;
  int         rx_busy = 0;
  int         rx_cnt  = 0;
  int         rx_k    = 0;
  int         rx_start = 0;
  logic [7:0] rx_sh;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      rx_busy = 0;
    end else if (rx_busy == 0) begin
      if (uart_tx === 1'b0) begin
        rx_busy  = 1;
        rx_cnt   = 0;
        rx_start = cyc;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % C == C / 2) begin
        rx_k = rx_cnt / C;
        if (rx_k == 0) begin
          if (uart_tx !== 1'b0) rx_err++;
        end else if (rx_k <= 8) begin
          rx_sh[rx_k-1] = uart_tx;
        end else begin
          if (uart_tx !== 1'b1) rx_err++;
          rxq.push_back(rx_sh);
          rxs.push_back(rx_start);
          rx_busy = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_f [8];
  int         acc;

  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic set_stats(input logic [4:0] h, input logic [4:0] ha, input logic [4:0] hy,
                           input logic [4:0] e, input logic [4:0] s, input logic sl);
    logic [7:0] c;
    hunger = h; happiness = ha; hygiene = hy; energy = e; social = s; is_sleeping = sl;
    exp_f[0] = 8'hA5;
    exp_f[1] = {3'b000, h};
    exp_f[2] = {3'b000, ha};
    exp_f[3] = {3'b000, hy};
    exp_f[4] = {3'b000, e};
    exp_f[5] = {3'b000, s};
    exp_f[6] = {7'b0000000, sl};
    c = 8'h00;
    for (int i = 1; i <= 6; i++) begin
`ifdef STATS_TX_CRC8_EN
      c = crc_ref(c, exp_f[i]);
`else
      c = c ^ exp_f[i];
`endif
    end
    exp_f[7] = c;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nbytes"}, (rxq.size() >= 8), 1);
    for (int i = 0; i < 8; i++) begin
      if (rxq.size() > 0) begin
        check($sformatf("%s_b%0d", tag, i), rxq.pop_front(), exp_f[i]);
        void'(rxs.pop_front());
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, (done_cnt >= target), 1);
  endtask

  task automatic pulse_send();
    @(negedge clk);
    send = 1'b1;
    acc  = cyc + 1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic raw_pulse();
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  initial begin
    int base;
    int ok_tx, ok_busy, n;
    reset = 1'b1;
    send  = 1'b0;
    set_stats(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // Idle after reset
    ok_tx = 1; ok_busy = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) ok_tx = 0;
      if (busy !== 1'b0) ok_busy = 0;
    end
    check("idle_tx_high", ok_tx, 1);
    check("idle_busy_low", ok_busy, 1);
    check("idle_no_done", done_cnt, 0);
    check("idle_no_bytes", rxq.size(), 0);

    // Basic frame with acceptance-edge timing
    set_stats(5'd3, 5'd31, 5'd0, 5'd16, 5'd7, 1'b1);
    @(negedge clk);
    send = 1'b1;
    acc  = cyc + 1;
    @(posedge clk); #1;
    check("basic_busy_at_accept", busy, 1);
    check("basic_tx_high_at_accept", uart_tx, 1);
    @(negedge clk);
    send = 1'b0;
    @(posedge clk); #1;
    check("basic_tx_start_low", uart_tx, 0);
    wait_done(1, 8000, "basic");
    check("basic_done_latency", done_last - acc, 80 * C + 1);
    repeat (5) @(negedge clk);
    check("basic_done_single", done_cnt, 1);
    check("basic_busy_after", busy, 0);
    check("basic_tx_after", uart_tx, 1);
`ifndef STATS_TX_CRC8_EN
    check("basic_xor_const", exp_f[7], 8'h0A);
`endif
    check_frame("basic");
    check("basic_rx_err", rx_err, 0);

    // Snapshot held, sends during busy ignored
    base = done_cnt;
    pulse_send();
    repeat (2000) @(negedge clk);
    hunger = 5'd9;
    check("snap_busy_mid", busy, 1);
    raw_pulse();
    repeat (1500) @(negedge clk);
    raw_pulse();
    wait_done(base + 1, 8000, "snap");
    repeat (25 * C) @(negedge clk);
    check("snap_one_frame_done", done_cnt, base + 1);
    check("snap_one_frame_bytes", rxq.size(), 8);
    check("snap_busy_after", busy, 0);
    check_frame("snap");

    // Back-to-back frames with send held high
    set_stats(5'd9, 5'd21, 5'd30, 5'd1, 5'd12, 1'b0);
    base = done_cnt;
    @(negedge clk);
    send = 1'b1;
    acc  = cyc + 1;
    wait_done(base + 1, 8000, "b2b_first");
    repeat (20) @(negedge clk);
    send = 1'b0;
    wait_done(base + 2, 8000, "b2b_second");
    // accepted in the done cycle, start bit one edge later
    check("b2b_first_latency", done_prev - acc, 80 * C + 1);
    check("b2b_done_spacing", done_last - done_prev, 80 * C + 2);
    repeat (25 * C) @(negedge clk);
    check("b2b_no_third", done_cnt, base + 2);
    check("b2b_nbytes", rxq.size(), 16);
    if (rxs.size() >= 9) begin
      check("b2b_intra_spacing", rxs[7] - rxs[6], 10 * C);
      check("b2b_boundary_spacing", rxs[8] - rxs[7], 10 * C + 2);
    end
    check_frame("b2b_f1");
    check_frame("b2b_f2");
    check("b2b_rx_err", rx_err, 0);

    // Reset during the start bit of B3
    rxq.delete(); rxs.delete();
    set_stats(5'd3, 5'd31, 5'd0, 5'd16, 5'd7, 1'b1);
    base = done_cnt;
    pulse_send();
    n = 0;
    while (rxq.size() < 3 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_b3", (rxq.size() >= 3), 1);
    repeat (C) @(negedge clk);
    check("rst_mid_tx_low_before", uart_tx, 0);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_tx_high", uart_tx, 1);
    check("rst_mid_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2000) @(negedge clk);
    check("rst_mid_no_done", done_cnt, base);
    check("rst_mid_idle_tx", uart_tx, 1);
    rxq.delete(); rxs.delete();

    // Fresh frame after reset, all stats zero, sleeping
    set_stats(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    base = done_cnt;
    pulse_send();
    wait_done(base + 1, 8000, "fresh");
    check("fresh_done_latency", done_last - acc, 80 * C + 1);
    repeat (5) @(negedge clk);
    if (rxq.size() >= 8) begin
`ifdef STATS_TX_CRC8_EN
      check("fresh_b7_crc", rxq[7], 8'h07);
`else
      check("fresh_b7_xor", rxq[7], 8'h01);
`endif
    end
    check_frame("fresh");
    check("fresh_rx_err", rx_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
